mem_cache_ctrl: RTL and testbench

MEM_CACHE_CTRL -- requirements
Module: mem_cache_ctrl

---
 rtl/mem_cache_ctrl_pkg.sv | 48 ++++
 rtl/mem_cache_ctrl_data_array.sv | 31 +++
 rtl/mem_cache_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_cache_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_cache_ctrl_pkg.sv
// Shared types, geometry constants and address helpers for the direct-mapped,
// write-through data cache controller.
package mips_cache_pkg;

    localparam int LINES = 8;
    localparam int WORDS = 4;
    localparam int TAG_W = 25;
    localparam int IDX_W = 3;
    localparam int OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        WDONE
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] word;
        logic [1:0]       lane;
    } addr_t;

    function automatic addr_t split_addr(input logic [31:0] a);
        return addr_t'(a);
    endfunction

    function automatic logic [31:0] word_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [OFF_W-1:0] word);
        return {tag, idx, word, 2'b00};
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    // Byte loads pick the little-endian lane and sign-extend.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  lane,
                                                 input logic        byte_acc);
        logic [7:0] b;
        b = w[{lane, 3'b000} +: 8];
        return byte_acc ? {{24{b[7]}}, b} : w;
    endfunction

endpackage

// File: rtl/mem_cache_ctrl_data_array.sv
// 8x4x32 cache data storage: combinational read, one byte-enabled write port.
// Contents are never reset; the controller's valid bits gate their use.
module cache_data_array
    import mips_cache_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [OFF_W-1:0] wr_word_i,
    input  logic [3:0]       wr_be_i,
    input  logic [31:0]      wr_dat_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [OFF_W-1:0] rd_word_i,
    output logic [31:0]      rd_dat_o
);

    logic [31:0] mem_q [LINES][WORDS];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_idx_i][wr_word_i][b*8 +: 8] <= wr_dat_i[b*8 +: 8];
                end
            end
        end
    end

    assign rd_dat_o = mem_q[rd_idx_i][rd_word_i];

endmodule

// File: rtl/mem_cache_ctrl.sv
// Direct-mapped write-through/no-write-allocate cache: load hits return data the same cycle,
// misses fill 4 words then hit; stores write through and hold freeze until the memory ack.
module mem_cache_ctrl
    import mips_cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cache_en,
    input  logic        mem_write,
    input  logic        is_LB_SB,
    input  logic [31:0] address,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        freeze,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_t           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    addr_t       a;
    logic        hit;
    logic        fill_done;
    logic [3:0]  st_be;
    logic [31:0] st_dat;
    logic        arr_we;
    logic [OFF_W-1:0] arr_word;
    logic [3:0]  arr_be;
    logic [31:0] arr_dat;
    logic [31:0] rd_dat;

    assign a      = split_addr(address);
    assign hit    = valid_q[a.idx] && (tag_q[a.idx] == a.tag);
    assign st_be  = is_LB_SB ? lane_be(a.lane) : 4'b1111;
    assign st_dat = is_LB_SB ? {4{din[7:0]}} : din;

    cache_data_array u_data (
        .clk       (clk),
        .wr_en_i   (arr_we),
        .wr_idx_i  (a.idx),
        .wr_word_i (arr_word),
        .wr_be_i   (arr_be),
        .wr_dat_i  (arr_dat),
        .rd_idx_i  (a.idx),
        .rd_word_i (a.word),
        .rd_dat_o  (rd_dat)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        freeze    = 1'b0;
        dout      = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        arr_we    = 1'b0;
        arr_word  = a.word;
        arr_be    = 4'b1111;
        arr_dat   = mem_rdata;
        fill_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (cache_en) begin
                    if (mem_write) begin
                        freeze  = 1'b1;
                        state_d = WRITE;
                    end else if (hit) begin
                        dout = load_extract(rd_dat, a.lane, is_LB_SB);
                    end else begin
                        freeze  = 1'b1;
                        cnt_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                freeze   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = word_addr(a.tag, a.idx, cnt_q);
                if (mem_ack) begin
                    arr_we   = 1'b1;
                    arr_word = cnt_q;
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        fill_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WRITE: begin
                freeze    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {address[31:2], 2'b00};
                mem_wdata = st_dat;
                mem_be    = st_be;
                if (mem_ack) begin
                    // No-write-allocate: only a resident line absorbs the store.
                    arr_we  = hit;
                    arr_be  = st_be;
                    arr_dat = st_dat;
                    state_d = WDONE;
                end
            end
            WDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (fill_done) begin
                valid_q[a.idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[a.idx] <= a.tag;
        end
    end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Directed bench for mem_cache_ctrl with a 3-cycle-latency memory model and a
// transaction scoreboard of expected memory requests.
module tb_mem_cache_ctrl;

    logic        clk;
    logic        rst_b;
    logic        cache_en;
    logic        mem_write;
    logic        is_LB_SB;
    logic [31:0] address;
    logic [31:0] din;
    logic [31:0] dout;
    logic        freeze;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        obs_q[$];
    logic [31:0] mem_m [logic [31:0]];
    int          n_vec;
    int          n_err;
    bit          stray_ack;

    mem_cache_ctrl dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cache_en  (cache_en),
        .mem_write (mem_write),
        .is_LB_SB  (is_LB_SB),
        .address   (address),
        .din       (din),
        .dout      (dout),
        .freeze    (freeze),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mrd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem_m.exists(wa)) return mem_m[wa];
        return wa ^ 32'hC3A5_F00F;
    endfunction

    function automatic logic [31:0] sext_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    // Memory responder: acks every third cycle of an active request.
    initial begin
        int   wc;
        txn_t t;
        logic [31:0] w;
        wc        = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                wc++;
                if (wc == 3) begin
                    wc      = 0;
                    mem_ack = 1'b1;
                    t.we    = mem_we;
                    t.addr  = mem_addr;
                    t.wdata = mem_wdata;
                    t.be    = mem_be;
                    obs_q.push_back(t);
                    if (mem_we) begin
                        w = mrd(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                        mem_m[{mem_addr[31:2], 2'b00}] = w;
                    end else begin
                        mem_rdata = mrd(mem_addr);
                    end
                end
            end else begin
                wc = 0;
                if (stray_ack) begin
                    stray_ack = 1'b0;
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hDEAD_BEEF;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_rd(input logic [31:0] a);
        txn_t t;
        t.we = 1'b0; t.addr = a; t.wdata = '0; t.be = '0;
        exp_q.push_back(t);
    endtask

    task automatic push_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) push_rd(base + 32'(i * 4));
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        txn_t t;
        t.we = 1'b1; t.addr = a; t.wdata = d; t.be = be;
        exp_q.push_back(t);
    endtask

    task automatic check_txns(input string tag);
        txn_t e;
        txn_t o;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_we"}, {31'b0, o.we}, {31'b0, e.we});
            chk({tag, "_addr"}, o.addr, e.addr);
            if (e.we) begin
                chk({tag, "_wdata"}, o.wdata, e.wdata);
                chk({tag, "_be"}, {28'b0, o.be}, {28'b0, e.be});
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Drive one access and wait (bounded) for freeze to drop; returns dout then.
    task automatic access(input logic we, input logic bt, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] dv, output int cyc);
        @(negedge clk);
        cache_en  = 1'b1;
        mem_write = we;
        is_LB_SB  = bt;
        address   = a;
        din       = d;
        #1;
        cyc = 0;
        while (freeze === 1'b1 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 200) chk("freeze_timeout", {31'b0, freeze}, 32'd0);
        dv        = dout;
        cache_en  = 1'b0;
        mem_write = 1'b0;
        is_LB_SB  = 1'b0;
    endtask

    task automatic load(input string tag, input logic bt, input logic [31:0] a,
                        input logic [31:0] exp_d, input int exp_cyc);
        logic [31:0] dv;
        int          cyc;
        access(1'b0, bt, a, 32'h0, dv, cyc);
        chk({tag, "_dout"}, dv, exp_d);
        chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check_txns(tag);
    endtask

    task automatic store(input string tag, input logic bt, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_wd, input logic [3:0] exp_be);
        logic [31:0] dv;
        int          cyc;
        push_wr({a[31:2], 2'b00}, exp_wd, exp_be);
        access(1'b1, bt, a, d, dv, cyc);
        chk({tag, "_cycles"}, 32'(cyc), 32'd4);
        @(negedge clk);
        #1;
        chk({tag, "_post_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_post_freeze"}, {31'b0, freeze}, 32'd0);
        check_txns(tag);
    endtask

    initial begin
        int w;
        n_vec     = 0;
        n_err     = 0;
        stray_ack = 1'b0;
        rst_b     = 1'b0;
        cache_en  = 1'b0;
        mem_write = 1'b0;
        is_LB_SB  = 1'b0;
        address   = '0;
        din       = '0;

        @(negedge clk);
        #1;
        chk("rst_freeze", {31'b0, freeze}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        push_fill(32'h40);
        load("cold_lw40", 1'b0, 32'h40, mrd(32'h40), 13);
        load("hit_lw48", 1'b0, 32'h48, mrd(32'h48), 0);

        store("sb41", 1'b1, 32'h41, 32'h0000_0085, 32'h8585_8585, 4'b0010);
        load("hit_lb41", 1'b1, 32'h41, 32'hFFFF_FF85, 0);
        load("hit_lb40", 1'b1, 32'h40, sext_byte(mrd(32'h40), 2'd0), 0);
        load("hit_lw43", 1'b0, 32'h43, mrd(32'h40), 0);

        store("sw_miss1000", 1'b0, 32'h1000, 32'h1234_5678, 32'h1234_5678, 4'b1111);
        push_fill(32'h1000);
        load("fill_lw1000", 1'b0, 32'h1000, 32'h1234_5678, 13);

        push_fill(32'hC0);
        load("conflict_c0", 1'b0, 32'hC0, mrd(32'hC0), 13);
        push_fill(32'h40);
        load("refill_lw40", 1'b0, 32'h40, mrd(32'h40), 13);

        store("sw_hit46", 1'b0, 32'h46, 32'hA5A5_1234, 32'hA5A5_1234, 4'b1111);
        load("hit_lw44", 1'b0, 32'h44, 32'hA5A5_1234, 0);
        load("hit_lb47", 1'b1, 32'h47, 32'hFFFF_FFA5, 0);

        @(negedge clk);
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("stray_req", {31'b0, mem_req}, 32'd0);
        chk("stray_freeze", {31'b0, freeze}, 32'd0);
        load("stray_hit48", 1'b0, 32'h48, mrd(32'h48), 0);

        @(negedge clk);
        cache_en  = 1'b1;
        mem_write = 1'b0;
        is_LB_SB  = 1'b0;
        address   = 32'h80;
        w = 0;
        while (obs_q.size() < 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("midfill_acks", 32'(obs_q.size()), 32'd2);
        rst_b = 1'b0;
        #1;
        chk("midfill_req", {31'b0, mem_req}, 32'd0);
        chk("midfill_be", {28'b0, mem_be}, 32'd0);
        chk("midfill_freeze", {31'b0, freeze}, 32'd1);
        cache_en = 1'b0;
        #1;
        chk("midfill_idle_freeze", {31'b0, freeze}, 32'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        obs_q.delete();
        exp_q.delete();

        push_fill(32'h80);
        load("post_rst_lw80", 1'b0, 32'h80, mrd(32'h80), 13);
        push_fill(32'h40);
        load("post_rst_lw40", 1'b0, 32'h40, mrd(32'h40), 13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
